// File: rtl/interface05_pkg.sv
// Shared types and default sizing for the Interface05 collector.
// Provides the FSM state enum, default frame geometry and the response word type.
package interface05_pkg;

  localparam int unsigned DEF_WIDTH   = 10;
  localparam int unsigned DEF_DEPTH   = 10;
  localparam int unsigned DEF_LATENCY = 1;
  localparam int unsigned CNT_W       = 4;

  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/interface05_collector_if.sv
// Request/response link between the Interface05 collector and its responder.
//   c  : request strobe, driven by the collector (master)
//   cc : response word, driven by the responder (slave)
interface interface05_collector_if #(
  parameter int unsigned WIDTH = interface05_pkg::DEF_WIDTH
);

  logic             c;
  logic [WIDTH-1:0] cc;

  modport master (output c, input cc);
  modport slave  (input c, output cc);

endinterface

// File: rtl/interface05_collector.sv
// Interface05 collector: issues DEPTH requests per frame on bus.c, captures each
// response word from bus.cc LATENCY cycles later, and presents the assembled frame
// on o_ccc together with a one-cycle o_done pulse.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_start        : frame start, honoured in IDLE only
//   i_clear        : synchronous abort to IDLE, o_ccc keeps the last completed frame
//   bus            : master side of the request/response link (c out, cc in)
//   o_ccc          : last completed frame, row k at [k*WIDTH +: WIDTH]
//   o_busy         : high outside IDLE
//   o_done         : one-cycle pulse when o_ccc has just been updated
module interface05_collector
  import interface05_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_clear,
  interface05_collector_if.master  bus,
  output logic [DEPTH*WIDTH-1:0]   o_ccc,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FRAME_W = DEPTH * WIDTH;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic               last_c;
  int unsigned        base_c;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and word capture; i_cc is only looked at in the sample cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last_c  = 1'b0;
    base_c  = 32'(idx_q) * WIDTH;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = REQ;
          idx_d   = '0;
        end
      end
      REQ: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          buf_d[base_c +: WIDTH] = bus.cc;
          if (idx_q == IDX_W'(DEPTH - 1)) begin
            last_c  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over everything, including a frame completing this cycle
    if (i_clear) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      buf_d   = '0;
      last_c  = 1'b0;
    end
  end

  // Datapath and registered outputs; strobes follow the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      buf_q  <= '0;
      o_ccc  <= '0;
      bus.c  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      bus.c  <= (state_d == REQ);
      o_busy <= (state_d != IDLE);
      o_done <= (state_d == DONE);
      if (last_c) begin
        o_ccc <= buf_d;
      end
    end
  end

endmodule

// File: tb/tb_interface05_collector.sv
// Directed bench for interface05_collector: a default-sized instance (A) and a
// DEPTH=4/LATENCY=3 instance (B), each with a behavioural responder that drives X
// on cc outside its answer cycles. Expected frames are queued at start and popped
// when o_done is expected.
module tb_interface05_collector;
  import interface05_pkg::*;

  localparam int unsigned W       = 10;
  localparam int unsigned A_DEPTH = 10;
  localparam int unsigned A_LAT   = 1;
  localparam int unsigned B_DEPTH = 4;
  localparam int unsigned B_LAT   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, clear_a = 1'b0, start_b = 1'b0, clear_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [A_DEPTH*W-1:0] ccc_a;
  logic [B_DEPTH*W-1:0] ccc_b;

  int ncomp = 0;
  int nfail = 0;
  int seed_a = 0;
  int ra_idx, rb_idx;
  logic [1:0] sh_b;
  word_t rsp_b [4];
  logic [127:0] sb_a[$];
  logic [127:0] sb_b[$];

  interface05_collector_if #(.WIDTH(W)) bus_a ();
  interface05_collector_if #(.WIDTH(W)) bus_b ();

  interface05_collector #(.WIDTH(W), .DEPTH(A_DEPTH), .LATENCY(A_LAT)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_clear(clear_a),
    .bus(bus_a), .o_ccc(ccc_a), .o_busy(busy_a), .o_done(done_a)
  );

  interface05_collector #(.WIDTH(W), .DEPTH(B_DEPTH), .LATENCY(B_LAT)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_clear(clear_b),
    .bus(bus_b), .o_ccc(ccc_b), .o_busy(busy_b), .o_done(done_b)
  );

  always #5 clk = ~clk;

  // Responder A: answers 10*k+3+seed_a one cycle after each request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_idx   <= 0;
      bus_a.cc <= 'x;
    end else if (!busy_a) begin
      ra_idx   <= 0;
      bus_a.cc <= 'x;
    end else if (bus_a.c) begin
      bus_a.cc <= 10'(10 * ra_idx + 3 + seed_a);
      ra_idx   <= ra_idx + 1;
    end else begin
      bus_a.cc <= 'x;
    end
  end

  // Responder B: answers from a fixed table three cycles after each request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_idx   <= 0;
      sh_b     <= '0;
      bus_b.cc <= 'x;
    end else begin
      sh_b <= {sh_b[0], bus_b.c};
      if (sh_b[1]) begin
        bus_b.cc <= rsp_b[rb_idx % 4];
        rb_idx   <= rb_idx + 1;
      end else begin
        bus_b.cc <= 'x;
      end
      if (!busy_b) rb_idx <= 0;
    end
  end

  function automatic logic [127:0] frame_a(input int seed);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < int'(A_DEPTH); k++) f[k*W +: W] = 10'(10 * k + 3 + seed);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit which, input logic v);
    if (which) start_b = v;
    else       start_a = v;
  endtask

  // Raise start in a fresh cycle 0 and queue the frame it should produce
  task automatic begin_start(input bit which, input bit push, input logic [127:0] exp);
    @(posedge clk); #1;
    set_start(which, 1'b1);
    if (push) begin
      if (which) sb_b.push_back(exp);
      else       sb_a.push_back(exp);
    end
  endtask

  // Walk cycles 1..ncyc after begin_start, checking strobes against frame timing
  task automatic run_frames(input bit which, input int nfr, input int ncyc, input int poke_at);
    int depth, per, span, rel;
    bit ec, ed, eb;
    logic [127:0] exp, ccc;
    depth = which ? int'(B_DEPTH) : int'(A_DEPTH);
    per   = 1 + (which ? int'(B_LAT) : int'(A_LAT));
    span  = depth * per + 2;
    rel   = (nfr - 1) * span + 1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (i == rel) set_start(which, 1'b0);
      if (poke_at != 0 && i == poke_at) set_start(which, 1'b1);
      if (poke_at != 0 && i == poke_at + 1) set_start(which, 1'b0);
      ec = 1'b0; ed = 1'b0; eb = 1'b0;
      for (int f = 0; f < nfr; f++) begin
        int j;
        j = i - f * span - 1;
        if (j >= 0 && j < depth * per && (j % per) == 0) ec = 1'b1;
        if (j >= 0 && j <= depth * per) eb = 1'b1;
        if (j == depth * per) ed = 1'b1;
      end
      chk(which ? "b_o_c" : "a_o_c", 128'(which ? bus_b.c : bus_a.c), 128'(ec));
      chk(which ? "b_done" : "a_done", 128'(which ? done_b : done_a), 128'(ed));
      chk(which ? "b_busy" : "a_busy", 128'(which ? busy_b : busy_a), 128'(eb));
      if (ed) begin
        ccc = which ? 128'(ccc_b) : 128'(ccc_a);
        exp = '0;
        if (which && sb_b.size() > 0) exp = sb_b.pop_front();
        if (!which && sb_a.size() > 0) exp = sb_a.pop_front();
        chk(which ? "b_frame" : "a_frame", ccc, exp);
      end
    end
  endtask

  initial begin
    rsp_b[0] = 10'h3FF; rsp_b[1] = 10'h000; rsp_b[2] = 10'h155; rsp_b[3] = 10'h2AA;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_c",    128'(bus_a.c), '0);
    chk("rst_a_busy", 128'(busy_a),  '0);
    chk("rst_a_done", 128'(done_a),  '0);
    chk("rst_a_ccc",  128'(ccc_a),   '0);
    chk("rst_b_c",    128'(bus_b.c), '0);
    chk("rst_b_ccc",  128'(ccc_b),   '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Default frame, with a stray start pulse while busy
    seed_a = 0;
    begin_start(1'b0, 1'b1, frame_a(0));
    run_frames(1'b0, 1, 24, 5);

    // DEPTH=4 / LATENCY=3 frame with edge-pattern rows, start poked during DONE
    begin_start(1'b1, 1'b1, {10'h2AA, 10'h155, 10'h000, 10'h3FF});
    run_frames(1'b1, 1, 21, 17);

    // Start held high: two back-to-back frames then quiet
    begin_start(1'b0, 1'b1, frame_a(0));
    sb_a.push_back(frame_a(0));
    run_frames(1'b0, 2, 46, 0);

    // Abort in the WAIT cycle of word 5; last completed frame must survive
    seed_a = 100;
    begin_start(1'b0, 1'b0, '0);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_a = 1'b0;
    end
    chk("clr_pre_busy", 128'(busy_a), 128'(1));
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    chk("clr_c",    128'(bus_a.c), '0);
    chk("clr_busy", 128'(busy_a),  '0);
    chk("clr_done", 128'(done_a),  '0);
    chk("clr_ccc",  128'(ccc_a),   frame_a(0));
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk("clr_quiet_done", 128'(done_a), '0);
      chk("clr_quiet_c",    128'(bus_a.c), '0);
    end

    // Clear and start together in IDLE: stay idle
    start_a = 1'b1; clear_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; clear_a = 1'b0;
    @(posedge clk); #1;
    chk("clr_start_busy", 128'(busy_a), '0);
    chk("clr_start_c",    128'(bus_a.c), '0);

    // Restart after abort yields a fresh full frame
    begin_start(1'b0, 1'b1, frame_a(100));
    run_frames(1'b0, 1, 24, 0);

    // Async reset between edges while a request is out
    seed_a = 0;
    begin_start(1'b0, 1'b0, '0);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_a = 1'b0;
    end
    chk("arst_pre_c", 128'(bus_a.c), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("arst_c",     128'(bus_a.c), '0);
    chk("arst_busy",  128'(busy_a),  '0);
    chk("arst_done",  128'(done_a),  '0);
    chk("arst_ccc",   128'(ccc_a),   '0);
    chk("arst_b_ccc", 128'(ccc_b),   '0);
    @(negedge clk) rst_n = 1'b1;
    begin_start(1'b0, 1'b1, frame_a(0));
    run_frames(1'b0, 1, 24, 0);

    chk("sb_a_left", 128'(sb_a.size()), '0);
    chk("sb_b_left", 128'(sb_b.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
